// File: rtl/keypad_matrix_emulator_pkg.sv
// Shared definitions for the virtual 4x4 keypad responder:
// matrix geometry, FSM encoding and key index helper.
package keypad_matrix_emulator_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 4;
    localparam int KP_KEYS = KP_ROWS * KP_COLS;

    typedef enum logic {
        KP_IDLE   = 1'b0,
        KP_BOUNCE = 1'b1
    } kp_state_e;

    function automatic logic [3:0] kp_idx(input int r, input int c);
        return 4'(r * KP_COLS + c);
    endfunction

endpackage

// File: rtl/keypad_matrix_emulator_bounce_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11) supplying bounce levels.
// A zero seed is replaced so the register can never lock up at 0.
module bounce_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic q
);

    localparam logic [15:0] INIT = (SEED == 16'h0000) ? 16'h0001 : SEED;

    logic [15:0] sr;
    logic        fb;

    assign fb = sr[15] ^ sr[13] ^ sr[12] ^ sr[10];
    assign q  = sr[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= INIT;
        end else if (en) begin
            sr <= {sr[14:0], fb};
        end
    end

endmodule

// File: rtl/keypad_matrix_emulator.sv
// Keypad-side responder for a 4x4 row/col scanner: returns column levels
// for a virtual 16-key matrix, with optional contact bounce per command.
module keypad_matrix_emulator
    import keypad_matrix_emulator_pkg::*;
#(
    parameter int          BOUNCE_EN     = 1,
    parameter int          BOUNCE_CYCLES = 240000,
    parameter int          TOGGLE_DIV    = 4096,
    parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  row,
    output logic [3:0]  col,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [3:0]  cmd_idx,
    input  logic        cmd_press,
    output logic        cmd_done,
    output logic [15:0] key_state
);

    localparam int CW = (BOUNCE_CYCLES > 1) ? $clog2(BOUNCE_CYCLES) : 1;
    localparam int TW = (TOGGLE_DIV > 1) ? $clog2(TOGGLE_DIV) : 1;
    localparam logic [CW-1:0] CNT_LOAD  = CW'(BOUNCE_CYCLES - 1);
    localparam logic [TW-1:0] TDIV_LOAD = TW'(TOGGLE_DIV - 1);

    kp_state_e   state;
    kp_state_e   nstate;
    logic [3:0]  row_m;
    logic [3:0]  row_s;
    logic [3:0]  col_next;
    logic [15:0] contact;
    logic [3:0]  idx_q;
    logic        press_q;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tdiv;
    logic        accept;
    logic        change;
    logic        cnt_zero;
    logic        tdiv_zero;
    logic        lfsr_en;
    logic        lfsr_q;

    assign accept    = cmd_valid & cmd_ready;
    assign change    = cmd_press != key_state[cmd_idx];
    assign cnt_zero  = cnt == '0;
    assign tdiv_zero = tdiv == '0;

    bounce_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (lfsr_en),
        .q     (lfsr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= KP_IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            KP_IDLE: begin
                if (accept && change && BOUNCE_EN != 0) begin
                    nstate = KP_BOUNCE;
                end
            end
            KP_BOUNCE: begin
                if (cnt_zero) begin
                    nstate = KP_IDLE;
                end
            end
            default: nstate = KP_IDLE;
        endcase
    end

    // The final settle edge wins over a coinciding toggle edge.
    always_comb begin
        cmd_ready = state == KP_IDLE;
        lfsr_en   = (state == KP_BOUNCE) && tdiv_zero && !cnt_zero;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            contact   <= '0;
            key_state <= '0;
            idx_q     <= '0;
            press_q   <= 1'b0;
            cnt       <= '0;
            tdiv      <= '0;
            cmd_done  <= 1'b0;
        end else begin
            cmd_done <= 1'b0;
            if (accept) begin
                idx_q   <= cmd_idx;
                press_q <= cmd_press;
                if (!change) begin
                    cmd_done <= 1'b1;
                end else if (BOUNCE_EN == 0) begin
                    contact[cmd_idx]   <= cmd_press;
                    key_state[cmd_idx] <= cmd_press;
                    cmd_done           <= 1'b1;
                end else begin
                    contact[cmd_idx] <= cmd_press;
                    cnt              <= CNT_LOAD;
                    tdiv             <= TDIV_LOAD;
                end
            end else if (state == KP_BOUNCE) begin
                if (cnt_zero) begin
                    contact[idx_q]   <= press_q;
                    key_state[idx_q] <= press_q;
                    cmd_done         <= 1'b1;
                end else begin
                    cnt <= cnt - 1'b1;
                    if (tdiv_zero) begin
                        contact[idx_q] <= lfsr_q;
                        tdiv           <= TDIV_LOAD;
                    end else begin
                        tdiv <= tdiv - 1'b1;
                    end
                end
            end
        end
    end

    // Row strobes come from another clock domain; two flops before use.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_m <= 4'hF;
            row_s <= 4'hF;
            col   <= 4'hF;
        end else begin
            row_m <= row;
            row_s <= row_m;
            col   <= col_next;
        end
    end

    always_comb begin
        logic [3:0] hit;
        hit = '0;
        for (int r = 0; r < KP_ROWS; r++) begin
            for (int c = 0; c < KP_COLS; c++) begin
                hit[c] = hit[c] | (~row_s[r] & contact[kp_idx(r, c)]);
            end
        end
        col_next = ~hit;
    end

endmodule

// File: tb/tb_keypad_matrix_emulator.sv
// Bench for keypad_matrix_emulator: a clean-edge and a bouncing instance
// checked against a key-level model of the matrix.
module tb_keypad_matrix_emulator;

    localparam int BC = 64;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  row;
    logic        cmd_valid;
    logic [3:0]  cmd_idx;
    logic        cmd_press;
    logic        sel;

    logic [3:0]  col0, col1, col_o;
    logic        rdy0, rdy1, rdy_o;
    logic        done0, done1, done_o;
    logic [15:0] ks0, ks1, ks_o;
    logic        cv0, cv1;

    logic [15:0] mk0, mk1;
    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign cv0    = cmd_valid & ~sel;
    assign cv1    = cmd_valid & sel;
    assign col_o  = sel ? col1 : col0;
    assign rdy_o  = sel ? rdy1 : rdy0;
    assign done_o = sel ? done1 : done0;
    assign ks_o   = sel ? ks1 : ks0;

    keypad_matrix_emulator #(
        .BOUNCE_EN     (0),
        .BOUNCE_CYCLES (BC),
        .TOGGLE_DIV    (TD),
        .LFSR_SEED     (16'hACE1)
    ) u_clean (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col0),
        .cmd_valid (cv0),
        .cmd_ready (rdy0),
        .cmd_idx   (cmd_idx),
        .cmd_press (cmd_press),
        .cmd_done  (done0),
        .key_state (ks0)
    );

    keypad_matrix_emulator #(
        .BOUNCE_EN     (1),
        .BOUNCE_CYCLES (BC),
        .TOGGLE_DIV    (TD),
        .LFSR_SEED     (16'hACE1)
    ) u_bounce (
        .clk       (clk),
        .rst_n     (rst_n),
        .row       (row),
        .col       (col1),
        .cmd_valid (cv1),
        .cmd_ready (rdy1),
        .cmd_idx   (cmd_idx),
        .cmd_press (cmd_press),
        .cmd_done  (done1),
        .key_state (ks1)
    );

    // Column k%4 is pulled low by any pressed key on a low row k/4.
    function automatic logic [3:0] mcol(input logic [3:0] r,
                                        input logic [15:0] keys);
        logic [3:0] c;
        c = 4'hF;
        for (int k = 0; k < 16; k++) begin
            if (!r[k / 4] && keys[k]) c[k % 4] = 1'b0;
        end
        return c;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic setrow(input logic [3:0] r);
        row = r;
        repeat (3) tick();
    endtask

    task automatic send(input logic [3:0] i, input logic p, output int lat,
                        output int rlow, output int tog);
        int w;
        logic pc;
        w = 0;
        cmd_idx = i;
        cmd_press = p;
        while (!rdy_o && w < 300) begin
            tick();
            w++;
        end
        chk("ready_wait", 32'(w < 300), 1);
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        lat = 0;
        rlow = 0;
        tog = 0;
        pc = col_o[0];
        while (!done_o && lat < 300) begin
            if (!rdy_o) rlow++;
            tick();
            lat++;
            if (col_o[0] !== pc) tog++;
            pc = col_o[0];
        end
    endtask

    initial begin
        int lat, rlow, tog, d0, d1, dn;
        logic [3:0] ri;
        logic       rp;
        logic [3:0] rr;

        rst_n = 1'b0;
        row = 4'h0;
        cmd_valid = 1'b0;
        cmd_idx = '0;
        cmd_press = 1'b0;
        sel = 1'b0;
        mk0 = '0;
        mk1 = '0;

        repeat (3) tick();
        chk("rst_col", 32'(col0), 32'hF);
        chk("rst_col_b", 32'(col1), 32'hF);
        chk("rst_ks", 32'(ks0), 0);
        chk("rst_ready", 32'(rdy1), 1);
        rst_n = 1'b1;
        repeat (4) tick();
        chk("post_rst_col", 32'(col0), 32'hF);

        send(4'd6, 1'b1, lat, rlow, tog);
        mk0[6] = 1'b1;
        chk("clean_lat", 32'(lat), 0);
        chk("clean_ks", 32'(ks0), 32'h0040);
        row = 4'hF;
        repeat (4) tick();
        row = 4'b1101;
        repeat (2) tick();
        chk("row_lat2", 32'(col0), 32'hF);
        tick();
        chk("row_lat3", 32'(col0), 32'b1011);
        setrow(4'b1110);
        chk("row0_col", 32'(col0), 32'hF);

        for (int n = 0; n < 24; n++) begin
            ri = 4'($urandom_range(15));
            rp = 1'($urandom_range(1));
            send(ri, rp, lat, rlow, tog);
            mk0[ri] = rp;
            chk("rnd_clean_lat", 32'(lat), 0);
            chk("rnd_clean_ks", 32'(ks0), 32'(mk0));
            rr = 4'($urandom_range(15));
            setrow(rr);
            chk("rnd_clean_col", 32'(col0), 32'(mcol(rr, mk0)));
        end

        sel = 1'b1;
        setrow(4'b1110);
        chk("bnc_idle_col", 32'(col1), 32'hF);
        send(4'd0, 1'b1, lat, rlow, tog);
        mk1[0] = 1'b1;
        chk("bnc_lat", 32'(lat), BC);
        chk("bnc_ready_low", 32'(rlow), BC);
        chk("bnc_toggled", 32'(tog >= 2), 1);
        chk("bnc_ks", 32'(ks1), 32'h0001);
        tick();
        chk("bnc_done_pulse", 32'(done1), 0);
        for (int n = 0; n < 8; n++) begin
            chk("bnc_stable", 32'(col1[0]), 0);
            tick();
        end

        send(4'd0, 1'b1, lat, rlow, tog);
        chk("redundant_lat", 32'(lat), 0);
        chk("redundant_ready", 32'(rlow), 0);

        cmd_idx = 4'd5;
        cmd_press = 1'b1;
        cmd_valid = 1'b1;
        tick();
        cmd_idx = 4'd10;
        d0 = -1;
        d1 = -1;
        dn = 0;
        for (int n = 1; n <= 200; n++) begin
            tick();
            if (d0 >= 0 && cmd_valid) cmd_valid = 1'b0;
            if (done1) begin
                dn++;
                if (d0 < 0) d0 = n;
                else if (d1 < 0) d1 = n;
            end
        end
        cmd_valid = 1'b0;
        mk1[5] = 1'b1;
        mk1[10] = 1'b1;
        chk("b2b_done1", 32'(d0), BC);
        chk("b2b_done2", 32'(d1), 2 * BC + 1);
        chk("b2b_ndone", 32'(dn), 2);
        chk("b2b_ks", 32'(ks1), 32'(mk1));

        setrow(4'b1100);
        chk("ghost_col", 32'(col1), 32'b1100);
        chk("ghost_model", 32'(col1), 32'(mcol(4'b1100, mk1)));

        for (int n = 0; n < 4; n++) begin
            ri = 4'($urandom_range(15));
            rp = 1'($urandom_range(1));
            send(ri, rp, lat, rlow, tog);
            chk("rnd_bnc_lat", 32'(lat), (rp != mk1[ri]) ? BC : 0);
            mk1[ri] = rp;
            chk("rnd_bnc_ks", 32'(ks1), 32'(mk1));
            rr = 4'($urandom_range(15));
            setrow(rr);
            chk("rnd_bnc_col", 32'(col1), 32'(mcol(rr, mk1)));
        end

        setrow(4'b0111);
        cmd_idx = 4'd15;
        cmd_press = ~mk1[15];
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        repeat (30) tick();
        chk("mid_in_bounce", 32'(rdy1), 0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_col", 32'(col1), 32'hF);
        chk("mid_rst_ks", 32'(ks1), 0);
        chk("mid_rst_ready", 32'(rdy1), 1);
        chk("mid_rst_done", 32'(done1), 0);
        mk0 = '0;
        mk1 = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        dn = 0;
        for (int n = 0; n < 80; n++) begin
            tick();
            if (done1) dn++;
        end
        chk("mid_no_done", 32'(dn), 0);
        chk("mid_idle", 32'(rdy1), 1);
        setrow(4'h0);
        chk("mid_all_rel_col", 32'(col1), 32'hF);
        send(4'd15, 1'b0, lat, rlow, tog);
        chk("mid_redundant_lat", 32'(lat), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
